neuron_mac: RTL
===============

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter dataWidth, default 16, meaning the width of input samples, weights and bias.
REQ-002 SHALL have parameter weightIntWidth, default 4, meaning the integer bits of the fixed-point format; it has no arithmetic effect here and is carried for the downstream saturation stage.
REQ-003 SHALL have parameter numInputs, default 8, meaning the samples per dot product (>=2).
REQ-004 SHALL have parameter useRelu, default 1, meaning negative results are clamped to 0 at the output when set to 1.
REQ-005 clk  input  1  is the single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  is a synchronous, active-low reset.
REQ-007 in_valid  input  1  means an input sample is present.
REQ-008 in_data  input  dataWidth  is a signed two's-complement sample.
REQ-009 in_ready  output  1  means the block accepts a sample this cycle.
REQ-010 wt_wr_en  input  1  is the weight write strobe.
REQ-011 wt_wr_addr  input  clog2(numInputs)  is the weight index.
REQ-012 wt_wr_data  input  dataWidth  is a signed weight.
REQ-013 bias_wr_en  input  1  is the bias write strobe.
REQ-014 bias_wr_data  input  2*dataWidth  is the signed bias, pre-aligned to the product format.
REQ-015 out_valid  output  1  means out_sum is valid.
REQ-016 out_ready  input  1  means the consumer takes out_sum.
REQ-017 out_sum  output  2*dataWidth  is the signed dot product plus bias; it is the direct feed of the output saturation/truncation stage.

Function
REQ-018 SHALL implement a state machine with states ACC, BIAS and OUT.
REQ-019 In ACC, the block SHALL drive in_ready=1 and out_valid=0; on in_valid&in_ready it SHALL compute acc <= sat(acc + in_data*weight[cnt]) and cnt <= cnt+1.
REQ-020 Products SHALL be signed dataWidth x dataWidth multiplies to a 2*dataWidth result, computed combinationally in the accept cycle.
REQ-021 Accumulation SHALL saturate to signed 2*dataWidth bounds (max 0x7FFF_FFFF, min 0x8000_0000 for dataWidth=16), and SHALL never wrap.
REQ-022 Accepting sample index numInputs-1 SHALL move the state to BIAS, with cnt wrapping to 0.
REQ-023 BIAS SHALL take one cycle, performing acc <= sat(acc + bias), driving in_ready=0, and moving to OUT.
REQ-024 In OUT, the block SHALL drive out_valid=1 and in_ready=0, and out_sum SHALL equal acc, or 0 if useRelu=1 and acc<0.
REQ-025 out_sum SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 In OUT with out_ready=1, the block SHALL clear acc to 0 and return to ACC on the next edge; the first new sample SHALL be acceptable the cycle after the handshake.
REQ-027 Latency: out_valid SHALL rise 2 edges after the edge that accepts the last sample.
REQ-028 in_valid gaps SHALL be tolerated in ACC, with acc and cnt holding while in_valid=0.
REQ-029 Weight and bias writes SHALL be accepted in any state and take effect from the next cycle.
REQ-030 A same-cycle weight write and read of the same index SHALL use the old weight.
REQ-031 A weight or bias write during accumulation SHALL affect only products and bias-adds of later cycles.

Reset
REQ-032 With rst_n=0 at an edge, the block SHALL set state=ACC, cnt=0, acc=0, out_valid=0 and out_sum=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-033 Weight memory and bias register SHALL NOT be reset and SHALL retain contents across rst_n pulses.
REQ-034 A reset mid-ACC, BIAS or OUT SHALL abandon the partial result with no residue in the next dot product.

Verification
REQ-035 Reset check: hold rst_n=0 for 2 cycles, then release -> out_valid=0, out_sum=0, in_ready=1.
REQ-036 Basic: numInputs=4, weights all 0x0001, bias=10, inputs 1,2,3,4 back-to-back, out_ready=1 -> out_sum=20, out_valid high for exactly 1 cycle, 2 edges after the 4th accept.
REQ-037 Backpressure: same stimulus with out_ready=0 for 10 cycles -> out_valid held, out_sum=20 stable, in_ready=0; raise out_ready -> in_ready=1 on the next cycle.
REQ-038 Saturation: weights 0x7FFF, inputs 0x7FFF x4, bias 0 -> out_sum=0x7FFF_FFFF; weights 0x8000, inputs 0x7FFF x4 -> out_sum=0 with useRelu=1, and 0x8000_0000 with useRelu=0.
REQ-039 Mid-op reset and gaps: accept 2 samples, pulse rst_n low for 1 cycle, then send 1,2,3,4 with one idle cycle between each (weights 1, bias 10) -> out_sum=20.
REQ-040 Weight update: write weight[0]=2 in the same cycle sample 0 (value 1) is accepted, with other weights 1 and bias 0 -> first result=10; repeat the same inputs -> second result=11.

Source files
------------

// File: rtl/neuron_mac.sv
// neuron_mac: one neuron's multiply-accumulate datapath.
//
// Streams numInputs signed samples, multiplies each by its stored weight,
// accumulates with saturation to the signed 2*dataWidth range, adds a stored
// bias in a dedicated cycle, then presents the result (optionally ReLU-clamped)
// under a valid/ready handshake.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    sample handshake, in_data is the signed sample
//   wt_wr_en/addr/data   weight memory write port (usable in any state)
//   bias_wr_en/data      bias register write port, bias is in product format
//   out_valid/out_ready  result handshake, out_sum is the signed result
//
// Weight memory and bias register are intentionally not reset.
module neuron_mac #(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int numInputs      = 8,
  parameter int useRelu        = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [dataWidth-1:0]          in_data,
  output logic                          in_ready,
  input  logic                          wt_wr_en,
  input  logic [$clog2(numInputs)-1:0]  wt_wr_addr,
  input  logic [dataWidth-1:0]          wt_wr_data,
  input  logic                          bias_wr_en,
  input  logic [2*dataWidth-1:0]        bias_wr_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*dataWidth-1:0]        out_sum
);

  localparam int AW = 2 * dataWidth;
  localparam int CW = $clog2(numInputs);

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  // weightIntWidth only describes the fixed-point format for the downstream
  // saturation stage; it is checked here for sanity but never used in arithmetic.
  if (numInputs < 2 || weightIntWidth > dataWidth) begin : g_bad_config
    $error("neuron_mac: numInputs must be >= 2 and weightIntWidth <= dataWidth");
  end

  typedef enum logic [1:0] {
    ACC,
    BIAS,
    OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [AW-1:0]   bias_q;
  logic signed [dataWidth-1:0] weight_q [numInputs];
  logic signed [AW-1:0]   product;

  // Add with one guard bit; overflow is detected when the guard bit and the
  // result sign disagree, and the result is pinned to the matching bound.
  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (s[AW] != s[AW-1]) return s[AW] ? ACC_MIN : ACC_MAX;
    return s[AW-1:0];
  endfunction

  // Operands are sign-extended to AW bits; the low AW bits of that product are
  // exact because a dataWidth x dataWidth signed product always fits in AW bits.
  // The weight is read before any same-cycle write lands, so a colliding write
  // only affects later samples.
  assign product = AW'($signed(in_data)) * AW'(weight_q[cnt_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = sat_add(acc_q, product);
          if (cnt_q == CW'(numInputs - 1)) begin
            cnt_d   = '0;
            state_d = BIAS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      BIAS: begin
        acc_d   = sat_add(acc_q, bias_q);
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wt_wr_en && (int'(wt_wr_addr) < numInputs)) weight_q[wt_wr_addr] <= wt_wr_data;
    if (bias_wr_en) bias_q <= bias_wr_data;
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);

  always_comb begin
    out_sum = '0;
    if (state_q == OUT && !(useRelu != 0 && acc_q[AW-1])) out_sum = acc_q;
  end

endmodule
